pipe_sink_fifo: RTL
===================

Name: pipe_sink_fifo

Overview:
- Downstream neighbour of the valid-only adder pipeline, which has no output flops and no backpressure.
- Captures every `c`/`out_valid` beat into a small FIFO and re-presents the data on a ready/valid interface for consumers that can stall.
- Since the producer cannot be stalled, the block absorbs bursts up to DEPTH words, flags overflow and drops the excess beats.

Parameters:
- WIDTH, 32, data width in bits; matches the adder result.
- DEPTH, 4, number of FIFO entries; must be a power of two, >= 2.
- AW, $clog2(DEPTH), pointer index width; derived, not to be overridden.

Ports:
- clk  input  1  clock; all flops on posedge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  WIDTH  producer data (the adder pipeline's `c`).
- in_valid  input  1  producer valid (the adder pipeline's `out_valid`); no backpressure exists.
- out_data  output  WIDTH  head-of-FIFO data.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head word this cycle.
- level  output  AW+1  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- overflow  output  1  sticky; set when a beat is dropped.
- drop_count  output  16  number of dropped beats (present only with PIPE_SINK_DROP_COUNT_EN).

Behaviour:
- Reset (async assert on rst rising, synchronous release):
  - wr_ptr = rd_ptr = 0, so level = 0, out_valid = 0, full = 0.
  - overflow = 0, drop_count = 0.
  - Storage array is not reset; out_data is don't-care while out_valid = 0.
- Pointers:
  - wr_ptr and rd_ptr are AW+1 bits, and increment with natural binary wrap.
  - level = wr_ptr - rd_ptr, taken modulo 2^(AW+1).
  - empty when the pointers are equal; full when the index bits are equal and the MSBs differ.
- Terms:
  - pop = out_valid & out_ready.
  - push = in_valid & (!full | pop).
- Write: on push, mem[wr_ptr[AW-1:0]] <= in_data and wr_ptr increments.
- Read: out_data = mem[rd_ptr[AW-1:0]] (show-ahead, combinational read of registered storage). On pop, rd_ptr increments.
- Latency: a beat with in_valid=1 in cycle N appears on out_valid/out_data in cycle N+1 when the FIFO was empty. There is no combinational path from in_* to out_*.
- Simultaneous push and pop:
  - Both take effect; level is unchanged.
  - When full, a pop in the same cycle frees the slot, so the incoming beat is accepted, not dropped.
- Push into an empty FIFO while out_ready=1: no pop that cycle (out_valid is still 0). The word is popped at the earliest in N+1.
- Drop: in_valid & full & !pop.
  - Beat discarded; storage and pointers unchanged.
  - overflow <= 1; it stays 1 until reset.
- out_ready while empty: ignored; no pointer change.
- Reset mid-operation: all buffered words are discarded, out_valid falls asynchronously, and overflow clears.
- Consumer contract: out_data is stable while out_valid=1 and out_ready=0 (standard ready/valid hold).

Optional Feature:
- Macro: PIPE_SINK_DROP_COUNT_EN.
- Defined:
  - drop_count port exists.
  - 16-bit counter increments by 1 on every drop cycle and saturates at 16'hFFFF (no wrap).
  - Reset to 0.
- Undefined:
  - Port and counter are absent.
  - overflow still reports drops.

Decomposition:
- Package pipe_pkg:
  - localparam WORD_W = 32.
  - localparam DROP_CNT_W = 16.
  - typedef logic [WORD_W-1:0] word_t.
  - typedef logic [DROP_CNT_W-1:0] drop_cnt_t.
- Sub-module pipe_sink_fifo_mem:
  - DEPTH x WIDTH register array, one write port, one async read port.
  - Instantiated once.
  - Pointer, flag and counter logic stays in the top module.

Test Plan:
- Single beat: in_valid=1, in_data=32'h0000_0005 with out_ready=1 -> out_valid=1 with out_data=5 exactly one cycle later; popped that cycle; level returns to 0.
- Fill without consuming: out_ready=0, 4 beats 1,2,3,4 -> full=1, level=4, out_data=1; then out_ready=1 -> outputs 1,2,3,4 in order, out_valid=0 after.
- Overflow: DEPTH=4 full, out_ready=0, in_valid with 9 -> overflow=1, level stays 4, 9 never appears. With the macro defined, drop_count=1.
- Full with simultaneous push/pop: full, out_ready=1, in_valid data 7 -> pop 1 and accept 7; full stays 1; overflow stays 0; 7 is emitted last.
- Stall hold: out_valid=1, out_ready=0 for 5 cycles while in_valid=0 -> out_data stays constant across all 5 cycles.
- Async reset mid-burst: assert rst between clock edges with level=3 and overflow=1 -> out_valid=0, level=0, overflow=0 before the next clk edge; after release, the next beat emerges normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared word and counter types for the adder pipeline sink.
package pipe_pkg;
  localparam int WORD_W     = 32;
  localparam int DROP_CNT_W = 16;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [DROP_CNT_W-1:0] drop_cnt_t;
endpackage

// File: rtl/pipe_sink_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the owning FIFO's pointers.
module pipe_sink_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage write
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_sink_fifo.sv
// Show-ahead FIFO that absorbs an unstallable valid-only stream and re-presents it as ready/valid.
// Define PIPE_SINK_DROP_COUNT_EN to add a saturating drop_count output.
module pipe_sink_fifo
  import pipe_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         full,
  output logic                         overflow
`ifdef PIPE_SINK_DROP_COUNT_EN
  ,
  output drop_cnt_t                    drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_overflow;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;

  // Pointer MSBs disambiguate full from empty when the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop   = !w_empty && out_ready;
  assign w_push  = in_valid && (!w_full || w_pop);
  assign w_drop  = in_valid && w_full && !w_pop;

  // Write and read pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else begin
      r_overflow <= r_overflow;
    end
  end

`ifdef PIPE_SINK_DROP_COUNT_EN
  drop_cnt_t r_drop_count;

  // Saturating count of discarded beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_count <= '0;
    end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end else begin
      r_drop_count <= r_drop_count;
    end
  end

  assign drop_count = r_drop_count;
`endif

  pipe_sink_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (in_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (out_data)
  );

  assign out_valid = !w_empty;
  assign level     = r_wr_ptr - r_rd_ptr;
  assign full      = w_full;
  assign overflow  = r_overflow;

endmodule
